// File: rtl/crc24_check.sv
// crc24_check: receive-side BLE CRC-24 checker.
// The PDU bits run through the CRC-24 LFSR. The 24 trailing received CRC bits
// are then compared MSB first against the remainder as it shifts out of lfsr[23].
module crc24_check #(
    parameter int CRC_STATE_BIT_WIDTH = 24,
    parameter int LEN_BIT_WIDTH       = 12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CRC_STATE_BIT_WIDTH-1:0] crc_state_init_bit,
    input  logic [LEN_BIT_WIDTH-1:0]       pdu_bit_len,
    input  logic                           start,
    input  logic                           data_in,
    input  logic                           data_in_valid,
    output logic                           busy,
    output logic                           crc_done,
    output logic                           crc_ok,
    output logic [4:0]                     crc_err_cnt,
    output logic [CRC_STATE_BIT_WIDTH-1:0] lfsr
);

    // The counter is shared between PDU bit counting and CRC bit counting.
    // It must reach 23 even when the length field is narrow.
    localparam int CNT_W = (LEN_BIT_WIDTH > 5) ? LEN_BIT_WIDTH : 5;

    // Feedback taps x^24+x^10+x^9+x^6+x^4+x^3+x+1. Bit 0 takes the feedback bit directly.
    localparam logic [23:0] POLY = 24'h00065B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PDU  = 2'd1,
        CRC  = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   len_m1;
    logic [LEN_BIT_WIDTH-1:0] len_q;
    logic [4:0]         mis_cnt;
    logic [4:0]         mis_nxt;
    logic               new_bit;
    logic               mismatch;
    logic [23:0]        lfsr_pdu;
    logic [23:0]        init_swap;

    // Next-state terms for the LFSR update and for the CRC compare.
    always_comb begin
        init_swap = {crc_state_init_bit[7:0], crc_state_init_bit[15:8],
                     crc_state_init_bit[23:16]};
        new_bit   = lfsr[23] ^ data_in;
        lfsr_pdu  = {lfsr[22:0], 1'b0} ^ ({24{new_bit}} & POLY);
        mismatch  = lfsr[23] ^ data_in;
        mis_nxt   = mis_cnt + 5'(mismatch);
        len_m1    = CNT_W'(len_q) - CNT_W'(1);
    end

    // Packet FSM. A start pulse takes priority over everything else, including a final CRC bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            lfsr        <= '0;
            bit_cnt     <= '0;
            len_q       <= '0;
            mis_cnt     <= '0;
            busy        <= 1'b0;
            crc_done    <= 1'b0;
            crc_ok      <= 1'b0;
            crc_err_cnt <= '0;
        end else begin
            crc_done <= 1'b0;
            if (start) begin
                lfsr        <= init_swap;
                bit_cnt     <= '0;
                mis_cnt     <= '0;
                len_q       <= pdu_bit_len;
                crc_ok      <= 1'b0;
                crc_err_cnt <= '0;
                busy        <= 1'b1;
                state       <= (pdu_bit_len != '0) ? PDU : CRC;
            end else if (data_in_valid) begin
                case (state)
                    PDU: begin
                        lfsr <= lfsr_pdu;
                        if (bit_cnt == len_m1) begin
                            bit_cnt <= '0;
                            state   <= CRC;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    CRC: begin
                        lfsr <= {lfsr[22:0], 1'b0};
                        if (bit_cnt == CNT_W'(23)) begin
                            bit_cnt     <= '0;
                            mis_cnt     <= '0;
                            state       <= IDLE;
                            busy        <= 1'b0;
                            crc_done    <= 1'b1;
                            crc_ok      <= (mis_nxt == 5'd0);
                            crc_err_cnt <= mis_nxt;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            mis_cnt <= mis_nxt;
                        end
                    end
                    default: begin
                        // IDLE: received bits are ignored and the LFSR holds its value.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crc24_check.sv
// tb_crc24_check: scoreboard bench for crc24_check.
// Stimulus pushes the expected verdict for every packet that should complete.
// A negedge monitor pops and compares the verdict on each crc_done.
module tb_crc24_check;

    typedef struct {
        logic       ok;
        logic [4:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] crc_state_init_bit = '0;
    logic [11:0] pdu_bit_len = '0;
    logic        start = 1'b0;
    logic        data_in = 1'b0;
    logic        data_in_valid = 1'b0;
    logic        busy, crc_done, crc_ok;
    logic [4:0]  crc_err_cnt;
    logic [23:0] lfsr;

    int   checks = 0;
    int   errors = 0;
    int   dones  = 0;
    int   pushed = 0;
    exp_t exp_q[$];
    logic pkt[$];

    crc24_check #(.CRC_STATE_BIT_WIDTH(24), .LEN_BIT_WIDTH(12)) dut (
        .clk(clk), .rst(rst), .crc_state_init_bit(crc_state_init_bit),
        .pdu_bit_len(pdu_bit_len), .start(start), .data_in(data_in),
        .data_in_valid(data_in_valid), .busy(busy), .crc_done(crc_done),
        .crc_ok(crc_ok), .crc_err_cnt(crc_err_cnt), .lfsr(lfsr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Transmit-side generator: serial CRC-24 over pkt[0:len-1] from a swapped init.
    function automatic logic [23:0] gen_crc(input logic [23:0] init, input int len);
        logic [23:0] r;
        logic        fb;
        r = {init[7:0], init[15:8], init[23:16]};
        for (int i = 0; i < len; i++) begin
            fb = r[23] ^ pkt[i];
            r  = r << 1;
            if (fb) r = r ^ 24'h00065B;
        end
        return r;
    endfunction

    task automatic push_exp(input logic ok, input logic [4:0] cnt);
        exp_t e;
        e.ok  = ok;
        e.cnt = cnt;
        exp_q.push_back(e);
        pushed++;
    endtask

    // Pulse start, optionally carrying a valid data bit in the same cycle.
    task automatic start_pkt(input logic [23:0] init, input int len,
                             input logic with_bit, input logic b);
        crc_state_init_bit = init;
        pdu_bit_len        = 12'(len);
        start              = 1'b1;
        data_in_valid      = with_bit;
        data_in            = b;
        @(posedge clk); #1;
        start         = 1'b0;
        data_in_valid = 1'b0;
        pdu_bit_len   = 12'($urandom);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("lfsr_after_start", 32'(lfsr), 32'({init[7:0], init[15:8], init[23:16]}));
    endtask

    // Send pkt[from:to-1] with up to gap_max idle cycles (random data) before each bit.
    task automatic feed(input int from, input int to, input int gap_max);
        for (int i = from; i < to; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                data_in       = 1'($urandom);
                data_in_valid = 1'b0;
                @(posedge clk); #1;
            end
            data_in       = pkt[i];
            data_in_valid = 1'b1;
            @(posedge clk); #1;
        end
        data_in_valid = 1'b0;
    endtask

    // Build a random PDU followed by the generator's CRC, MSB first.
    task automatic build_good(input logic [23:0] init, input int len);
        logic [23:0] c;
        pkt.delete();
        for (int i = 0; i < len; i++) pkt.push_back(1'($urandom));
        c = gen_crc(init, len);
        for (int i = 23; i >= 0; i--) pkt.push_back(c[i]);
    endtask

    // Monitor: every crc_done must match the oldest expected verdict.
    always @(negedge clk) begin
        if (rst && crc_done) begin
            dones++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_crc_done ok=%0d cnt=%0d expected=none", crc_ok, crc_err_cnt);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("verdict_ok", 32'(crc_ok), 32'(e.ok));
                chk("verdict_cnt", 32'(crc_err_cnt), 32'(e.cnt));
                chk("busy_low_at_done", 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL timeout pending=%0d expected=0", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] c;
        logic        last;
        int          len;

        // Reset state.
        #2;
        chk("rst_lfsr", 32'(lfsr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(crc_done), 32'd0);
        chk("rst_ok", 32'(crc_ok), 32'd0);
        chk("rst_cnt", 32'(crc_err_cnt), 32'd0);
        #10 rst = 1'b1;
        @(posedge clk); #1;

        // Valid bits in IDLE must not move the LFSR.
        for (int i = 0; i < 6; i++) begin
            data_in = 1'b1;
            data_in_valid = 1'(i & 1);
            @(posedge clk); #1;
        end
        data_in_valid = 1'b0;
        chk("idle_lfsr_hold", 32'(lfsr), 32'd0);

        // Init 0, length 0, 24 zero bits.
        pkt.delete();
        for (int i = 0; i < 24; i++) pkt.push_back(1'b0);
        push_exp(1'b1, 5'd0);
        start_pkt(24'h000000, 0, 1'b0, 1'b0);
        feed(0, 24, 0);

        // Init 0x555555, length 0, alternating bits 0,1,0,1...
        pkt.delete();
        for (int i = 0; i < 24; i++) pkt.push_back(1'(i & 1));
        push_exp(1'b1, 5'd0);
        start_pkt(24'h555555, 0, 1'b0, 1'b0);
        feed(0, 24, 1);

        // Same, with the 5th bit flipped, checked back to back.
        pkt[4] = ~pkt[4];
        push_exp(1'b0, 5'd1);
        start_pkt(24'h555555, 0, 1'b0, 1'b0);
        feed(0, 24, 0);

        // Every CRC bit wrong.
        for (int i = 0; i < 24; i++) pkt[i] = ~pkt[i];
        pkt[4] = ~pkt[4];
        push_exp(1'b0, 5'd24);
        start_pkt(24'h555555, 0, 1'b0, 1'b0);
        feed(0, 24, 0);

        // Init 0, one PDU bit '1': the remainder is the tap mask 0x00065B.
        c = 24'h00065B;
        pkt.delete();
        pkt.push_back(1'b1);
        for (int i = 23; i >= 0; i--) pkt.push_back(c[i]);
        push_exp(1'b1, 5'd0);
        start_pkt(24'h000000, 1, 1'b0, 1'b0);
        feed(0, 25, 2);

        // Byte swap of the init value.
        start_pkt(24'h123456, 0, 1'b0, 1'b0);
        chk("swap_lfsr", 32'(lfsr), 32'h563412);

        // Generator cross-check: clean packets, then a single flipped PDU bit.
        for (int n = 0; n < 10; n++) begin
            int fi;
            len = $urandom_range(16, 300);
            build_good(24'h555555, len);
            push_exp(1'b1, 5'd0);
            start_pkt(24'h555555, len, 1'b0, 1'b0);
            feed(0, len + 24, 2);
            fi = $urandom_range(0, len - 1);
            pkt[fi] = ~pkt[fi];
            c = gen_crc(24'h555555, len);
            for (int i = 0; i < 24; i++) c[23 - i] = c[23 - i] ^ pkt[len + i];
            chk("model_detects_flip", 32'(c != 24'h0), 32'd1);
            push_exp(1'b0, 5'($countones(c)));
            start_pkt(24'h555555, len, 1'b0, 1'b0);
            feed(0, len + 24, 2);
        end

        // Abort: restart at PDU bit 40 of packet A, then packet B completes cleanly.
        build_good(24'h555555, 100);
        start_pkt(24'h555555, 100, 1'b0, 1'b0);
        feed(0, 40, 1);
        build_good(24'hABCDEF, 64);
        push_exp(1'b1, 5'd0);
        start_pkt(24'hABCDEF, 64, 1'b0, 1'b0);
        feed(0, 88, 1);

        // Start coincident with the final CRC bit: no verdict, the new packet is armed.
        build_good(24'h555555, 20);
        start_pkt(24'h555555, 20, 1'b0, 1'b0);
        feed(0, 43, 1);
        last = pkt[43];
        build_good(24'h0F0F0F, 33);
        push_exp(1'b1, 5'd0);
        start_pkt(24'h0F0F0F, 33, 1'b1, last);
        feed(0, 57, 1);

        // Asynchronous reset at CRC bit 10.
        build_good(24'h555555, 32);
        start_pkt(24'h555555, 32, 1'b0, 1'b0);
        feed(0, 42, 0);
        chk("busy_before_rst", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_lfsr", 32'(lfsr), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(crc_done), 32'd0);
        chk("midrst_ok", 32'(crc_ok), 32'd0);
        chk("midrst_cnt", 32'(crc_err_cnt), 32'd0);
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;
        build_good(24'h555555, 48);
        push_exp(1'b1, 5'd0);
        start_pkt(24'h555555, 48, 1'b0, 1'b0);
        feed(0, 72, 1);

        repeat (5) @(posedge clk);
        #1;
        chk("pending_verdicts", 32'(exp_q.size()), 32'd0);
        chk("done_pulses", 32'(dones), 32'(pushed));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
